// File: rtl/hdmi_tmds_decoder_pkg.sv
// hdmi_pkg: shared definitions for the TMDS channel decoder.
//   TMDS_CTRL_00..11 : 10-bit control tokens, named by the {C1,C0} they carry
//   align_state_t    : word-aligner FSM state
//   tmds_is_ctrl()   : 1 when a 10-bit word is one of the four control tokens
package hdmi_pkg;

    localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
    localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
    localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
    localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } align_state_t;

    function automatic logic tmds_is_ctrl(input logic [9:0] q);
        logic hit;
        case (q)
            TMDS_CTRL_00, TMDS_CTRL_01, TMDS_CTRL_10, TMDS_CTRL_11: hit = 1'b1;
            default:                                                hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/hdmi_tmds_decoder_if.sv
// Character stream bundle between the channel deserializer and the video-timing stage.
//   raw_valid/raw_word : deserialized 10-bit word, bit 0 earliest on the wire
//   out_valid          : decoded character valid (only while locked)
//   data_out/de_out    : data byte and data-enable (data_out is 0 for control tokens)
//   ctrl_out           : {C1,C0} of the last control token
//   locked/offset      : aligner status and current slip offset (0-9)
// master = upstream/sink side, slave = the decoder.
interface hdmi_tmds_decoder_if;

    logic       raw_valid;
    logic [9:0] raw_word;
    logic       out_valid;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de_out;
    logic       locked;
    logic [3:0] offset;

    modport master (
        output raw_valid, raw_word,
        input  out_valid, data_out, ctrl_out, de_out, locked, offset
    );

    modport slave (
        input  raw_valid, raw_word,
        output out_valid, data_out, ctrl_out, de_out, locked, offset
    );

endinterface

// File: rtl/hdmi_tmds_decoder_tmds_char_decode.sv
// tmds_char_decode: combinational TMDS 10b -> 8b character decode.
//   q       : aligned 10-bit character
//   data    : decoded data byte (meaningful only when is_ctrl = 0)
//   ctrl    : {C1,C0} for a control token, 00 otherwise
//   is_ctrl : q is one of the four control tokens
module tmds_char_decode
    import hdmi_pkg::*;
(
    input  logic [9:0] q,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       is_ctrl
);

    logic [7:0] qi;

    always_comb begin
        qi      = q[9] ? ~q[7:0] : q[7:0];
        data    = '0;
        data[0] = qi[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = q[8] ? (qi[i] ^ qi[i-1]) : ~(qi[i] ^ qi[i-1]);
        end
    end

    always_comb begin
        case (q)
            TMDS_CTRL_00: ctrl = 2'b00;
            TMDS_CTRL_01: ctrl = 2'b01;
            TMDS_CTRL_10: ctrl = 2'b10;
            TMDS_CTRL_11: ctrl = 2'b11;
            default:      ctrl = 2'b00;
        endcase
        is_ctrl = tmds_is_ctrl(q);
    end

endmodule

// File: rtl/hdmi_tmds_decoder.sv
// hdmi_tmds_decoder: per-channel TMDS word aligner and character decoder.
//   clk : TMDS character clock
//   rst : synchronous active-high reset
//   bus : hdmi_tmds_decoder_if.slave (raw words in, decoded characters and status out)
// Parameters: LOCK_COUNT tokens in a row to lock, SEARCH_WINDOW words per offset
// before slipping, MAX_GAP words without a token before dropping lock.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_SEARCH | hunting for LOCK_COUNT consecutive tokens, slipping offset
// ST_LOCKED | aligned; out_valid enabled, watching the token gap
module hdmi_tmds_decoder
    import hdmi_pkg::*;
#(
    parameter int LOCK_COUNT    = 8,
    parameter int SEARCH_WINDOW = 64,
    parameter int MAX_GAP       = 4096
) (
    input logic               clk,
    input logic               rst,
    hdmi_tmds_decoder_if.slave bus
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W = $clog2(SEARCH_WINDOW + 1);
    localparam int GAP_W = $clog2(MAX_GAP + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_COUNT);
    localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(SEARCH_WINDOW);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MAX_GAP);

    align_state_t     state_q;
    logic [9:0]       prev_word;
    logic [3:0]       offset_q;
    logic             locked_q;
    logic [RUN_W-1:0] run_q, run_nxt;
    logic [WIN_W-1:0] win_q, win_nxt;
    logic [GAP_W-1:0] gap_q, gap_nxt;

    logic [19:0] cat;
    logic [9:0]  window;
    logic [7:0]  win_data_unused;
    logic [1:0]  win_ctrl_unused;
    logic        win_is_ctrl;

    logic       s1_valid, s2_valid;
    logic [9:0] s1_q;
    logic [7:0] dec_data, data_q;
    logic [1:0] dec_ctrl, ctrl_q;
    logic       dec_is_ctrl, de_q;

    // Earlier word in the low half so offset counts serial bits forward in time.
    assign cat    = {bus.raw_word, prev_word};
    assign window = cat[offset_q +: 10];

    tmds_char_decode u_win_dec (
        .q       (window),
        .data    (win_data_unused),
        .ctrl    (win_ctrl_unused),
        .is_ctrl (win_is_ctrl)
    );

    always_comb begin
        run_nxt = win_is_ctrl ? ((run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1)) : '0;
        win_nxt = (win_q == WIN_MAX) ? win_q : win_q + WIN_W'(1);
        gap_nxt = win_is_ctrl ? '0 : ((gap_q == GAP_MAX) ? gap_q : gap_q + GAP_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SEARCH;
            prev_word <= '0;
            offset_q  <= '0;
            locked_q  <= 1'b0;
            run_q     <= '0;
            win_q     <= '0;
            gap_q     <= '0;
        end else if (bus.raw_valid) begin
            prev_word <= bus.raw_word;
            case (state_q)
                ST_SEARCH: begin
                    // Lock takes priority over a window expiry on the same word.
                    if (run_nxt == RUN_MAX) begin
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                        gap_q    <= '0;
                        run_q    <= '0;
                        win_q    <= '0;
                    end else if (win_nxt == WIN_MAX) begin
                        offset_q <= (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                        run_q    <= '0;
                        win_q    <= '0;
                    end else begin
                        run_q <= run_nxt;
                        win_q <= win_nxt;
                    end
                end
                ST_LOCKED: begin
                    if (gap_nxt == GAP_MAX) begin
                        state_q  <= ST_SEARCH;
                        locked_q <= 1'b0;
                        gap_q    <= '0;
                        run_q    <= '0;
                        win_q    <= '0;
                    end else begin
                        gap_q <= gap_nxt;
                    end
                end
                default: state_q <= ST_SEARCH;
            endcase
        end
    end

    tmds_char_decode u_s2_dec (
        .q       (s1_q),
        .data    (dec_data),
        .ctrl    (dec_ctrl),
        .is_ctrl (dec_is_ctrl)
    );

    // Bubbles propagate through the valid bits; payload registers hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s2_valid <= 1'b0;
            data_q   <= '0;
            ctrl_q   <= '0;
            de_q     <= 1'b0;
        end else begin
            s1_valid <= bus.raw_valid;
            if (bus.raw_valid) begin
                s1_q <= window;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                de_q   <= ~dec_is_ctrl;
                data_q <= dec_is_ctrl ? 8'h00 : dec_data;
                if (dec_is_ctrl) begin
                    ctrl_q <= dec_ctrl;
                end
            end
        end
    end

    assign bus.out_valid = s2_valid & locked_q;
    assign bus.data_out  = data_q;
    assign bus.ctrl_out  = ctrl_q;
    assign bus.de_out    = de_q;
    assign bus.locked    = locked_q;
    assign bus.offset    = offset_q;

endmodule

// File: tb/tb_hdmi_tmds_decoder.sv
module tb_hdmi_tmds_decoder;

    localparam int LC = 8;
    localparam int SW = 64;
    localparam int MG = 16;

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         de;
        logic [1:0] c;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    hdmi_tmds_decoder_if bus ();

    hdmi_tmds_decoder #(.LOCK_COUNT(LC), .SEARCH_WINDOW(SW), .MAX_GAP(MG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [9:0] m_prev;
    int         m_off, m_run, m_win, m_gap;
    bit         m_locked;
    logic [1:0] m_ctrl;
    ent_t       sb[$];

    function automatic bit ref_tok(input logic [9:0] q, output logic [1:0] c);
        c = 2'b00;
        case (q)
            10'h354: begin c = 2'b00; return 1'b1; end
            10'h0AB: begin c = 2'b01; return 1'b1; end
            10'h154: begin c = 2'b10; return 1'b1; end
            10'h2AB: begin c = 2'b11; return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] ref_data(input logic [9:0] q);
        logic [7:0] qi, t;
        qi = q[9] ? ~q[7:0] : q[7:0];
        t  = qi ^ {qi[6:0], 1'b0};
        if (!q[8]) t[7:1] = ~t[7:1];
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_off = 0; m_run = 0; m_win = 0; m_gap = 0;
        m_locked = 1'b0; m_ctrl = 2'b00;
        sb.delete();
        sb.push_back('{v: 1'b0, d: 8'h00, de: 1'b0, c: 2'b00});
    endtask

    task automatic rst_cycle(input bit force_valid);
        rst = 1'b1;
        bus.raw_valid = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
        bus.raw_word  = 10'($urandom_range(0, 1023));
        @(posedge clk); #1;
        model_reset();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_ctrl_out", bus.ctrl_out, 0);
        chk("rst_de_out", bus.de_out, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_offset", bus.offset, 0);
    endtask

    task automatic step(input bit v, input logic [9:0] w);
        ent_t e, o;
        logic [19:0] sh;
        logic [9:0]  q;
        logic [1:0]  c;
        bit          tok;
        rst = 1'b0;
        bus.raw_valid = v;
        bus.raw_word  = w;
        e = '{v: v, d: 8'h00, de: 1'b0, c: m_ctrl};
        if (v) begin
            sh  = {w, m_prev} >> m_off;
            q   = sh[9:0];
            tok = ref_tok(q, c);
            if (tok) begin
                m_ctrl = c;
                e.c    = c;
            end else begin
                e.de = 1'b1;
                e.d  = ref_data(q);
            end
            if (!m_locked) begin
                m_run = tok ? m_run + 1 : 0;
                if (m_win < SW) m_win++;
                if (m_run >= LC) begin
                    m_locked = 1'b1; m_gap = 0; m_run = 0; m_win = 0;
                end else if (m_win >= SW) begin
                    m_off = (m_off == 9) ? 0 : m_off + 1;
                    m_run = 0; m_win = 0;
                end
            end else begin
                m_gap = tok ? 0 : m_gap + 1;
                if (m_gap >= MG) begin
                    m_locked = 1'b0; m_gap = 0; m_run = 0; m_win = 0;
                end
            end
            m_prev = w;
        end
        sb.push_back(e);
        @(posedge clk); #1;
        o = sb.pop_front();
        chk("locked", bus.locked, m_locked);
        chk("offset", bus.offset, m_off);
        chk("out_valid", bus.out_valid, o.v && m_locked);
        if (o.v && m_locked) begin
            chk("data_out", bus.data_out, o.d);
            chk("de_out", bus.de_out, o.de);
            chk("ctrl_out", bus.ctrl_out, o.c);
        end
    endtask

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        logic [1:0] c;
        w = 10'($urandom_range(0, 1023));
        if (ref_tok(w, c)) w = w ^ 10'h001;
        return w;
    endfunction

    initial begin
        int lock_at;
        bus.raw_valid = 1'b0;
        bus.raw_word  = '0;
        model_reset();

        for (int i = 0; i < 3; i++) rst_cycle(1'b0);

        // At offset 0 the window is prev_word, which is 0 after reset, so the
        // first word is not a token and lock completes on the 9th word.
        lock_at = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 10'h354);
            if (bus.locked && lock_at == 0) lock_at = i;
        end
        chk("aligned_lock_word", lock_at, 9);
        chk("aligned_ctrl", bus.ctrl_out, 2'b00);

        // Window lags one word, output two more cycles.
        step(1'b1, 10'h100);
        step(1'b1, 10'h200);
        step(1'b1, 10'h2AB);
        chk("d100_data", bus.data_out, 8'h00);
        chk("d100_de", bus.de_out, 1);
        step(1'b1, 10'h2AB);
        chk("d200_data", bus.data_out, 8'hFF);
        chk("d200_de", bus.de_out, 1);
        step(1'b1, 10'h2AB);
        chk("c11_ctrl", bus.ctrl_out, 2'b11);
        chk("c11_de", bus.de_out, 0);

        // First window is the trailing 0x2AB, then 16 data windows.
        lock_at = 0;
        for (int i = 1; i <= 17; i++) begin
            step(1'b1, 10'h100);
            if (!bus.locked && lock_at == 0) lock_at = i;
        end
        chk("gap_drop_word", lock_at, 17);
        chk("gap_offset_kept", bus.offset, 0);

        lock_at = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 10'h154);
            if (bus.locked && lock_at == 0) lock_at = i;
        end
        chk("relock_word", lock_at, 9);
        chk("relock_ctrl", bus.ctrl_out, 2'b10);
        chk("relock_valid", bus.out_valid, 1);

        for (int i = 0; i < 6; i++) step(1'b1, rand_data());
        step(1'b1, 10'h154);
        step(1'b1, 10'h154);

        rst_cycle(1'b1);

        // 0x0AB rotated by 3 serial bits: only offset 3 exposes the token.
        lock_at = 0;
        for (int i = 1; i <= 205; i++) begin
            step(1'b1, 10'h159);
            if (i == 63)  chk("rot_off_63", bus.offset, 0);
            if (i == 64)  chk("rot_off_64", bus.offset, 1);
            if (i == 128) chk("rot_off_128", bus.offset, 2);
            if (i == 192) chk("rot_off_192", bus.offset, 3);
            if (i == 201) begin
                chk("rot_out_valid", bus.out_valid, 1);
                chk("rot_ctrl", bus.ctrl_out, 2'b01);
                chk("rot_de", bus.de_out, 0);
            end
            if (bus.locked && lock_at == 0) lock_at = i;
        end
        chk("rot_lock_word", lock_at, 3 * 64 + 8);
        chk("rot_lock_offset", bus.offset, 3);

        rst_cycle(1'b0);
        lock_at = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 10'h354);
            if (bus.locked && lock_at == 0) lock_at = i;
            step(1'b0, 10'($urandom_range(0, 1023)));
        end
        chk("alt_lock_valid_words", lock_at, 9);

        rst_cycle(1'b1);
        step(1'b1, 10'h354);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
